// File: rtl/pipe_column_serializer.sv
// Parallel-in, serial-out feeder for the obstacle shift registers: MSB-first pattern, then SPACING zero bits.
// Optional build macro PIPE_COLUMN_SERIALIZER_REPEAT_EN re-emits the last pattern back to back.
module pipe_column_serializer #(
    parameter int WIDTH   = 30,
    parameter int SPACING = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_shift_en,
    input  logic             i_load_valid,
    input  logic [WIDTH-1:0] i_load_data,
    output logic             o_load_ready,
    output logic             o_data_out,
    output logic             o_data_valid,
    output logic             o_busy,
    output logic             o_word_done
);

    localparam int TOTAL = WIDTH + SPACING;
    localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [CW-1:0] LAST_PAT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(TOTAL - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_SPACE = 2'd2
    } state_t;

`ifdef PIPE_COLUMN_SERIALIZER_REPEAT_EN
    localparam state_t EOW_STATE = ST_SHIFT;
`else
    localparam state_t EOW_STATE = ST_IDLE;
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_cnt;
    logic             r_data_out;
    logic             r_data_valid;
    logic             r_word_done;

    logic             w_emit;
    logic             w_pat_end;
    logic             w_eow;
    logic             w_load_ready;
    logic             w_load;
    logic             w_start;
    logic [WIDTH-1:0] w_start_pat;

    assign w_emit    = i_shift_en && (r_state != ST_IDLE);
    assign w_pat_end = w_emit && (r_state == ST_SHIFT) && (r_cnt == LAST_PAT);
    assign w_eow     = w_emit && (r_cnt == LAST_BIT);

`ifdef PIPE_COLUMN_SERIALIZER_REPEAT_EN
    logic [WIDTH-1:0] r_hold;

    // The end-of-word cycle doubles as a load slot so emission never gaps.
    assign w_load_ready = (r_state == ST_IDLE) || w_eow;
    assign w_load       = i_load_valid && w_load_ready;
    assign w_start      = w_load || w_eow;
    assign w_start_pat  = w_load ? i_load_data : r_hold;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold <= '0;
        end else if (w_load) begin
            r_hold <= i_load_data;
        end
    end
`else
    assign w_load_ready = (r_state == ST_IDLE);
    assign w_load       = i_load_valid && w_load_ready;
    assign w_start      = w_load;
    assign w_start_pat  = i_load_data;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_pat_end) begin
                    w_state_next = (SPACING > 0) ? ST_SPACE : EOW_STATE;
                end
            end
            ST_SPACE: begin
                if (w_eow) begin
                    w_state_next = EOW_STATE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // A start in the same cycle as an emit overrides the shift/count update.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sreg       <= '0;
            r_cnt        <= '0;
            r_data_out   <= 1'b0;
            r_data_valid <= 1'b0;
            r_word_done  <= 1'b0;
        end else begin
            r_data_valid <= w_emit;
            r_word_done  <= w_eow;
            if (w_emit) begin
                r_data_out <= (r_state == ST_SHIFT) && r_sreg[WIDTH-1];
                r_sreg     <= r_sreg << 1;
                r_cnt      <= r_cnt + CW'(1);
            end
            if (w_start) begin
                r_sreg <= w_start_pat;
                r_cnt  <= '0;
            end
        end
    end

    assign o_load_ready = w_load_ready;
    assign o_data_out   = r_data_out;
    assign o_data_valid = r_data_valid;
    assign o_word_done  = r_word_done;
    assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pipe_column_serializer.sv
// Self-checking bench for pipe_column_serializer: random stalls and junk loads against a bit-queue model.
module tb_pipe_column_serializer;

    localparam int W = 30;
    localparam int S = 4;
    localparam int N = W + S;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         shift_en = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         load_ready;
    logic         data_out;
    logic         data_valid;
    logic         busy;
    logic         word_done;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];

`ifdef PIPE_COLUMN_SERIALIZER_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    pipe_column_serializer #(.WIDTH(W), .SPACING(S)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_shift_en   (shift_en),
        .i_load_valid (load_valid),
        .i_load_data  (load_data),
        .o_load_ready (load_ready),
        .o_data_out   (data_out),
        .o_data_valid (data_valid),
        .o_busy       (busy),
        .o_word_done  (word_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected serial stream for one word: pattern MSB first, then S zeros.
    function automatic void append_word(input logic [W-1:0] pat);
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(pat[i]);
        for (int i = 0; i < S; i++) exp_q.push_back(1'b0);
    endfunction

    task automatic apply_reset(input int n);
        reset = 1'b1;
        shift_en = 1'b0;
        load_valid = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_load(input logic [W-1:0] pat, input bit se);
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_before_load: got %b want 1", load_ready);
        end
        load_valid = 1'b1;
        load_data = pat;
        shift_en = se;
        tick();
        load_valid = 1'b0;
        load_data = W'($urandom);
        shift_en = 1'b0;
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_emit_on_load: data_valid=%b want 0", data_valid);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_load: got %b want 1", busy);
        end
    endtask

    // mode 0: shift_en always, 1: one cycle in three, 2: random
    task automatic run_word(input int mode, input bit inject, input int stop_after,
                            input int load_at, input logic [W-1:0] load_pat);
        int idx = 0;
        int cyc = 0;
        bit s;
        bit exp_wd;
        bit exp_busy;
        while (idx < stop_after && cyc < N * 20) begin
            case (mode)
                0:       s = 1'b1;
                1:       s = (cyc % 3 == 2);
                default: s = 1'($urandom_range(0, 1));
            endcase
            shift_en = s;
            if (s && idx == load_at) begin
                load_valid = 1'b1;
                load_data = load_pat;
            end else if (inject && idx < N - 1) begin
                load_valid = 1'($urandom_range(0, 1));
                load_data = ($urandom_range(0, 1) == 1) ? 30'h15555555 : W'($urandom);
            end
            tick();
            cyc++;
            load_valid = 1'b0;
            exp_wd = s && ((idx % N) == N - 1);
            checks++;
            if (data_valid !== s) begin
                errors++;
                $display("FAIL data_valid bit%0d: got %b want %b", idx, data_valid, s);
            end
            if (s) begin
                checks++;
                if (data_out !== exp_q[idx]) begin
                    errors++;
                    $display("FAIL data_out bit%0d: got %b want %b", idx, data_out, exp_q[idx]);
                end
                idx++;
            end
            checks++;
            if (word_done !== exp_wd) begin
                errors++;
                $display("FAIL word_done bit%0d: got %b want %b", idx, word_done, exp_wd);
            end
            exp_busy = REPEAT || (idx < N);
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy bit%0d: got %b want %b", idx, busy, exp_busy);
            end
            if (!REPEAT) begin
                checks++;
                if (load_ready !== !exp_busy) begin
                    errors++;
                    $display("FAIL load_ready bit%0d: got %b want %b", idx, load_ready, !exp_busy);
                end
            end
        end
        if (idx < stop_after) begin
            errors++;
            $display("FAIL word_timeout: got %0d bits want %0d", idx, stop_after);
        end
        shift_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        shift_en = 1'b1;
        load_valid = 1'b1;
        load_data = 30'h3FF003FF;
        tick();
        tick();
        checks += 4;
        if (data_out !== 1'b0)   begin errors++; $display("FAIL rst_data_out: got %b want 0", data_out); end
        if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_data_valid: got %b want 0", data_valid); end
        if (word_done !== 1'b0)  begin errors++; $display("FAIL rst_word_done: got %b want 0", word_done); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        reset = 1'b0;
        shift_en = 1'b0;
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_load_ready: got %b want 1", load_ready); end
    endtask

    task automatic test_full_rate();
        apply_reset(2);
        append_word(30'h3FF003FF);
        do_load(30'h3FF003FF, 1'b1);
        run_word(0, 1'b0, N, -1, '0);
        if (!REPEAT) begin
            shift_en = 1'b1;
            repeat (3) begin
                tick();
                checks++;
                if (data_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_no_emit: data_valid=%b want 0", data_valid);
                end
            end
            shift_en = 1'b0;
        end
    endtask

    task automatic test_stall();
        apply_reset(1);
        append_word(30'h3FF003FF);
        do_load(30'h3FF003FF, 1'b0);
        run_word(1, 1'b0, N, -1, '0);
    endtask

    task automatic test_reset_mid_word();
        apply_reset(1);
        append_word(30'h3FF003FF);
        do_load(30'h3FF003FF, 1'b0);
        run_word(0, 1'b0, 12, -1, '0);
        reset = 1'b1;
        shift_en = 1'b1;
        tick();
        reset = 1'b0;
        checks += 4;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL midrst_data_valid: got %b want 0", data_valid); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (word_done !== 1'b0)  begin errors++; $display("FAIL midrst_word_done: got %b want 0", word_done); end
        if (load_ready !== 1'b1) begin errors++; $display("FAIL midrst_load_ready: got %b want 1", load_ready); end
        tick();
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_resume: got %b want 0", data_valid); end
        shift_en = 1'b0;
        exp_q.delete();
        append_word(30'h00000001);
        do_load(30'h00000001, 1'b0);
        run_word(0, 1'b0, N, -1, '0);
    endtask

    task automatic test_ignored_load();
        apply_reset(1);
        append_word(30'h3FF003FF);
        do_load(30'h3FF003FF, 1'b0);
        run_word(0, 1'b1, N, -1, '0);
    endtask

    task automatic test_random();
        logic [W-1:0] pat;
        for (int k = 0; k < 6; k++) begin
            apply_reset(1);
            pat = W'($urandom);
            append_word(pat);
            do_load(pat, 1'($urandom_range(0, 1)));
            run_word(2, 1'b1, N, -1, '0);
        end
    endtask

    task automatic test_repeat();
        apply_reset(1);
        append_word(30'h3FF003FF);
        append_word(30'h3FF003FF);
        append_word(30'h3FFFFFFF);
        do_load(30'h3FF003FF, 1'b1);
        run_word(0, 1'b0, 3 * N, 2 * N - 1, 30'h3FFFFFFF);
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_stall();
        test_reset_mid_word();
        test_ignored_load();
        test_random();
        if (REPEAT) test_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_column_serializer.md
Name: pipe_column_serializer

Overview:
- Parallel-in, serial-out feeder for the game's 30-bit obstacle shift registers.
- Accepts a full pipe-column pattern (one bit per vertical cell, 1 = pipe, 0 = gap) through a valid/ready load handshake.
- Emits the pattern one bit per game tick (shift_en), MSB first, on data_out/data_valid, which drive the downstream register's data_in.
- Appends a fixed run of empty (0) spacing bits after each pattern so consecutive pipes are separated.

Parameters:
- WIDTH, 30, bits per column pattern; also the downstream register length.
- SPACING, 4, empty 0 bits appended after each pattern; 0 = no spacing.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- shift_en  input  1  game-tick enable; emit one bit in each cycle where it is high.
- load_valid  input  1  load_data holds a new pattern.
- load_data  input  WIDTH  column pattern; bit WIDTH-1 is emitted first.
- load_ready  output  1  serializer can accept a pattern this cycle.
- data_out  output  1  serial bit, registered.
- data_valid  output  1  registered; high for exactly one cycle per emitted bit.
- busy  output  1  high in SHIFT or SPACE state.
- word_done  output  1  one-cycle pulse, registered, coincident with the final bit of pattern plus spacing.

Behaviour:
- Reset (sync, reset=1 at a clk edge) takes priority over all other inputs:
  - state=IDLE, shift register and counter cleared.
  - data_out=0, data_valid=0, word_done=0, busy=0.
  - load_ready=1 in the following cycle.
  - Reset mid-word aborts the word with no partial completion: no word_done, no further data_valid.
- States:
  - IDLE: load_ready=1.
  - SHIFT: shifting out the WIDTH pattern bits.
  - SPACE: emitting SPACING zero bits.
- Load:
  - Accepted when load_valid && load_ready at a clk edge.
  - load_data is captured into the internal shift register, bit counter is cleared, state goes to SHIFT.
  - load_data is never sampled again for that word.
  - load_valid outside load_ready cycles is ignored; the held word must not be corrupted.
- In IDLE, a cycle with shift_en and an accepted load performs the load only; no bit is emitted that cycle.
- SHIFT, each shift_en cycle:
  - data_out <= sreg[WIDTH-1]; data_valid <= 1.
  - sreg shifts left, filling with 0; counter increments.
  - After bit WIDTH-1 is emitted: go to SPACE if SPACING>0, else end-of-word.
- SPACE, each shift_en cycle: data_out <= 0, data_valid <= 1, counter increments. After SPACING bits: end-of-word.
- Cycles with shift_en=0 hold all state; data_valid=0 and word_done=0 in the following cycle. data_out holds its last value but is meaningful only while data_valid=1.
- End-of-word cycle (the cycle emitting the final bit):
  - word_done <= 1 alongside data_valid.
  - Next state is IDLE (base build).
- Latency:
  - Load accepted at edge N → first bit is registered at the first edge M>N where shift_en=1.
  - One emitted bit per shift_en cycle.
  - Total WIDTH+SPACING data_valid pulses per word.
- Counter width: clog2(WIDTH+SPACING), minimum 1; must not wrap within a word.
- busy=1 exactly in SHIFT/SPACE.

Optional Feature:
- Macro: PIPE_COLUMN_SERIALIZER_REPEAT_EN.
- When defined:
  - A copy of the last accepted pattern is retained.
  - In the end-of-word cycle, load_ready is also asserted (combinationally: end-of-word && shift_en).
  - If load_valid is high that cycle, the new pattern is loaded; otherwise the retained pattern is reloaded.
  - The FSM goes directly to SHIFT with no idle gap, so bit emission is continuous. IDLE is entered only after reset, until the first load.
  - word_done still pulses per word.
- When undefined: behaviour exactly as above; load_ready=1 only in IDLE; no retained copy is synthesized.

Test Plan:
- Reset for 2 cycles → data_out=0, data_valid=0, word_done=0, busy=0; load_ready=1 the cycle after reset falls.
- Load 30'h3FF003FF, shift_en held 1 (WIDTH=30, SPACING=4) → 34 consecutive data_valid pulses:
  - ten 1s, ten 0s, ten 1s, then four 0s.
  - word_done only on pulse 34; busy falls and load_ready rises the next cycle.
- Same load, shift_en high 1 cycle in 3 → identical 34-bit sequence, one bit per shift_en; no data_valid on stall cycles.
- Reset asserted after the 12th bit → next cycle data_valid=0, busy=0, load_ready=1; no word_done. A fresh load of 30'h00000001 then emits 29 zeros, a 1, and four zeros.
- During SHIFT, drive load_valid=1 with load_data=30'h15555555 → ignored (load_ready=0); the remaining bits still match 30'h3FF003FF.
- Macro defined, load 30'h3FF003FF once, shift_en held 1 for 70 cycles → two back-to-back identical 34-bit words, word_done on bits 34 and 68, busy never falls. load_valid with 30'h3FFFFFFF at bit 68 → third word is all 1s plus four 0s.
